// File: rtl/alu_pkg.sv
// Shared ALU encodings and multiply-sequencer state type.
// Used by the ALU, the MUL sequencer and the execute-stage mux.
package alu_pkg;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_SHL = 5'b10000;
    localparam logic [4:0] FS_SHR = 5'b10100;

    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_Z = 1;
    localparam int ST_N = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response bundle of the shift-and-add MUL sequencer.
// master issues operands; slave is the sequencer.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             carry_seen;

    modport master (
        output start, mcand, mplier,
        input  busy, done, product, carry_seen
    );

    modport slave (
        input  start, mcand, mplier,
        output busy, done, product, carry_seen
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Low-half unsigned multiply by sequencing the shared ALU (ADD/SHL/SHR).
// Optional macro MUL_EARLY_EXIT_EN: finish once the shifted multiplier is 0.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    alu_mul_sequencer_if.slave bus,
    output logic             alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_fs,
    input  logic [WIDTH-1:0] alu_f,
    input  logic [3:0]       alu_status
);

    seq_state_t       state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] mc, mc_n;
    logic [WIDTH-1:0] mp, mp_n;
    logic [CNT_W-1:0] iter, iter_n;
    logic             carry_q, carry_n;
    logic             busy_w;
    logic             unused_status;

    assign unused_status = alu_status[ST_V] ^ alu_status[ST_N];

    // State and datapath registers; reset abandons any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
            iter    <= '0;
            carry_q <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            mc      <= mc_n;
            mp      <= mp_n;
            iter    <= iter_n;
            carry_q <= carry_n;
        end
    end

    // Next state, ALU drive and result capture for each step.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        mc_n    = mc;
        mp_n    = mp;
        iter_n  = iter;
        carry_n = carry_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_fs  = FS_AND;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    acc_n   = '0;
                    mc_n    = bus.mcand;
                    mp_n    = bus.mplier;
                    iter_n  = '0;
                    carry_n = 1'b0;
                    state_n = S_ADD;
                end
            end
            S_ADD: begin
                alu_fs  = FS_ADD;
                alu_a   = acc;
                alu_b   = mp[0] ? mc : '0;
                acc_n   = alu_f;
                carry_n = carry_q | alu_status[ST_C];
                state_n = S_SHL;
            end
            S_SHL: begin
                alu_fs  = FS_SHL;
                alu_a   = mc;
                alu_b   = WIDTH'(1);
                mc_n    = alu_f;
                state_n = S_SHR;
            end
            S_SHR: begin
                alu_fs  = FS_SHR;
                alu_a   = mp;
                alu_b   = WIDTH'(1);
                mp_n    = alu_f;
                iter_n  = iter + CNT_W'(1);
                if (iter == CNT_W'(WIDTH - 1)) begin
                    state_n = S_DONE;
`ifdef MUL_EARLY_EXIT_EN
                end else if (alu_status[ST_Z]) begin
                    state_n = S_DONE;
`endif
                end else begin
                    state_n = S_ADD;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy_w = (state == S_ADD) ||
                    (state == S_SHL) ||
                    (state == S_SHR);

    assign alu_sel        = busy_w;
    assign bus.busy       = busy_w;
    assign bus.done       = (state == S_DONE);
    assign bus.product    = acc;
    assign bus.carry_seen = carry_q;

endmodule
